measure_ctrl: RTL and testbench
===============================

MEASURE_CTRL -- requirements
Module: measure_ctrl

Interface
REQ-001 Parameter GATE_CYCLES, default 0, RUN length in clk cycles; 0 selects manual stop.
REQ-002 Parameter MAX_EXPONENT, default 9, exponent at which the counter is treated as full.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  level input; a rising edge requests a measurement.
REQ-006 stop  input  1  level input; a rising edge ends a manual measurement.
REQ-007 cnt_base  input  7  base value from the counter, 0..99.
REQ-008 cnt_exponent  input  4  exponent value from the counter.
REQ-009 cnt_rst  output  1  clear pulse to the counter.
REQ-010 cnt_en  output  1  count enable to the counter.
REQ-011 result_base  output  7  latched base of the last measurement.
REQ-012 result_exponent  output  4  latched exponent of the last measurement.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 done  output  1  one-cycle pulse; result is valid in the same cycle.
REQ-015 overflow  output  1  the last measurement hit full scale.

Function
REQ-016 The block SHALL implement the states IDLE, CLEAR, RUN, LATCH and DONE in one registered state machine.
REQ-017 Edge detect SHALL be start_edge = start AND NOT start_q, and likewise for stop, where start_q and stop_q are the previous-cycle samples.
REQ-018 IDLE: start_edge SHALL go to CLEAR; stop_edge SHALL be ignored.
REQ-019 CLEAR SHALL last exactly 1 cycle and then go to RUN, with cnt_rst=1 only in CLEAR.
REQ-020 CLEAR entry SHALL clear overflow and the gate counter; start and stop SHALL be ignored in CLEAR.
REQ-021 RUN SHALL hold cnt_en=1 and cnt_en SHALL be 0 in every other state.
REQ-022 In RUN, a 32-bit gate counter SHALL increment every cycle.
REQ-023 RUN exit priority: (a) cnt_exponent==MAX_EXPONENT and cnt_base==99 -> LATCH and set overflow=1.
REQ-024 RUN exit priority: (b) stop_edge -> LATCH.
REQ-025 RUN exit priority: (c) GATE_CYCLES!=0 and gate counter==GATE_CYCLES-1 -> LATCH.
REQ-026 When GATE_CYCLES!=0, RUN SHALL last exactly GATE_CYCLES cycles unless (a) or (b) fires first.
REQ-027 In RUN, start_edge SHALL be ignored; simultaneous start_edge and stop_edge SHALL act as stop only.
REQ-028 LATCH SHALL last 1 cycle with cnt_en=0, and on the exit edge SHALL capture cnt_base/cnt_exponent into result_base/result_exponent, then go to DONE.
REQ-029 DONE SHALL assert done=1 for exactly 1 cycle and then go to IDLE; start_edge in LATCH or DONE SHALL be ignored.
REQ-030 From a start_edge sampled in IDLE, the latency SHALL be: cnt_rst high the next cycle, cnt_en high the cycle after that.
REQ-031 From the RUN exit edge, the latency SHALL be: done high 2 cycles later.
REQ-032 result_* and overflow SHALL hold their values until the next LATCH or CLEAR.
REQ-033 cnt_rst, cnt_en, busy and done SHALL be decoded from the state register only, with no input-to-output combinational path.

Reset
REQ-034 rst SHALL asynchronously force: state=IDLE, all outputs 0, gate counter 0, start_q=1 and stop_q=1.
REQ-035 Because start_q and stop_q reset to 1, an input held high through reset SHALL NOT produce an edge.
REQ-036 rst asserted during RUN SHALL abort the measurement with no done pulse, and result_* SHALL read 0.
REQ-037 After rst deasserts, a new start_edge SHALL start a normal measurement.

Verification
REQ-038 GATE_CYCLES=25, pulse start -> cnt_rst 1 cycle, cnt_en 25 cycles, done pulse, result_base=25, result_exponent=0, overflow=0.
REQ-039 GATE_CYCLES=0, start, stop rising edge on the 10th RUN cycle -> result_base=10, result_exponent=0, done once.
REQ-040 GATE_CYCLES=0, MAX_EXPONENT=1, start, no stop -> exit after 990 RUN cycles, result_base=99, result_exponent=1, overflow=1.
REQ-041 Simultaneous start and stop edges in RUN -> measurement ends, no restart, busy=0 two cycles after done.
REQ-042 rst pulse mid-RUN -> cnt_en=0 immediately, busy=0, no done, result 0; a subsequent start completes normally.
REQ-043 start held high across rst deassertion -> stays IDLE; a later low-then-high edge on start starts a measurement.

Source files
------------

// File: rtl/measure_ctrl_if.sv
// rtl/measure_ctrl_if.sv - signal bundle between the measurement sequencer and its counter/host
//
// Purpose: groups the start/stop requests, the counter readback and control,
// and the latched measurement results into one interface.
// Modports:
//   slave  - the sequencer side (measure_ctrl): takes requests and counter
//            value, drives counter control and results.
//   master - the environment side: drives requests and counter value,
//            observes counter control and results.
// Signals:
//   start, stop        level requests; rising edges are acted on
//   cnt_base[6:0]      counter base value, 0..99
//   cnt_exponent[3:0]  counter exponent value
//   cnt_rst, cnt_en    counter clear pulse and count enable
//   result_base[6:0]   latched base of the last measurement
//   result_exponent    latched exponent of the last measurement
//   busy, done         sequencer activity and one-cycle completion pulse
//   overflow           last measurement reached full scale

interface measure_ctrl_if;
  logic       start;
  logic       stop;
  logic [6:0] cnt_base;
  logic [3:0] cnt_exponent;
  logic       cnt_rst;
  logic       cnt_en;
  logic [6:0] result_base;
  logic [3:0] result_exponent;
  logic       busy;
  logic       done;
  logic       overflow;

  modport slave (
    input  start,
    input  stop,
    input  cnt_base,
    input  cnt_exponent,
    output cnt_rst,
    output cnt_en,
    output result_base,
    output result_exponent,
    output busy,
    output done,
    output overflow
  );

  modport master (
    output start,
    output stop,
    output cnt_base,
    output cnt_exponent,
    input  cnt_rst,
    input  cnt_en,
    input  result_base,
    input  result_exponent,
    input  busy,
    input  done,
    input  overflow
  );
endinterface

// File: rtl/measure_ctrl.sv
// rtl/measure_ctrl.sv - gated/manual measurement sequencer for a decade counter
//
// Purpose: on a start edge, clears the external counter, enables it for a
// gate period (fixed length, manual stop, or until full scale), then latches
// the counter value and pulses done.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - measure_ctrl_if.slave (requests, counter readback/control, results)
// Parameters:
//   GATE_CYCLES  - RUN length in clk cycles; 0 selects manual stop
//   MAX_EXPONENT - exponent at which the counter is treated as full

module measure_ctrl #(
  parameter int unsigned GATE_CYCLES  = 0,
  parameter int unsigned MAX_EXPONENT = 9
) (
  input  logic          clk,
  input  logic          rst,
  measure_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    LATCH = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam bit          GATE_ENABLED = (GATE_CYCLES != 0);
  localparam int unsigned GATE_LAST    = GATE_ENABLED ? GATE_CYCLES - 1 : 0;

  state_t      state_q;
  logic        start_q;
  logic        stop_q;
  logic [31:0] gate_q;
  logic [31:0] gate_d;
  logic        cnt_rst_q;
  logic        cnt_en_q;
  logic        busy_q;
  logic        done_q;
  logic        overflow_q;
  logic [6:0]  result_base_q;
  logic [3:0]  result_exponent_q;

  logic start_edge;
  logic stop_edge;
  logic full_scale;
  logic gate_hit;

  assign start_edge = bus.start & ~start_q;
  assign stop_edge  = bus.stop  & ~stop_q;
  assign full_scale = (bus.cnt_exponent == 4'(MAX_EXPONENT)) && (bus.cnt_base == 7'd99);
  assign gate_hit   = GATE_ENABLED && (gate_q == 32'(GATE_LAST));
  assign gate_d     = gate_q + 32'd1;

  // Outputs are registered alongside the state so each one is a pure
  // function of the state register: no input reaches them combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      // Sampled inputs reset high so a level held through reset is not an edge.
      start_q           <= 1'b1;
      stop_q            <= 1'b1;
      gate_q            <= 32'd0;
      cnt_rst_q         <= 1'b0;
      cnt_en_q          <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      overflow_q        <= 1'b0;
      result_base_q     <= 7'd0;
      result_exponent_q <= 4'd0;
    end else begin
      start_q <= bus.start;
      stop_q  <= bus.stop;

      case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q    <= CLEAR;
            cnt_rst_q  <= 1'b1;
            busy_q     <= 1'b1;
            overflow_q <= 1'b0;
            gate_q     <= 32'd0;
          end
        end

        CLEAR: begin
          state_q   <= RUN;
          cnt_rst_q <= 1'b0;
          cnt_en_q  <= 1'b1;
        end

        RUN: begin
          gate_q <= gate_d;
          // Full scale wins over stop, stop wins over the gate timer;
          // a start edge here is ignored even if it coincides with stop.
          if (full_scale) begin
            state_q    <= LATCH;
            cnt_en_q   <= 1'b0;
            overflow_q <= 1'b1;
          end else if (stop_edge || gate_hit) begin
            state_q  <= LATCH;
            cnt_en_q <= 1'b0;
          end
        end

        LATCH: begin
          // Counter has been frozen for a cycle, so its value is stable here.
          state_q           <= DONE;
          result_base_q     <= bus.cnt_base;
          result_exponent_q <= bus.cnt_exponent;
          done_q            <= 1'b1;
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q   <= IDLE;
          cnt_rst_q <= 1'b0;
          cnt_en_q  <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cnt_rst         = cnt_rst_q;
  assign bus.cnt_en          = cnt_en_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.overflow        = overflow_q;
  assign bus.result_base     = result_base_q;
  assign bus.result_exponent = result_exponent_q;

endmodule

// File: tb/tb_measure_ctrl.sv
// tb/tb_measure_ctrl.sv - scoreboard bench for measure_ctrl in gated, manual and overflow setups

module tb_measure_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  measure_ctrl_if if_g ();
  measure_ctrl_if if_m ();
  measure_ctrl_if if_o ();

  measure_ctrl #(.GATE_CYCLES(25), .MAX_EXPONENT(9)) u_gate (.clk(clk), .rst(rst), .bus(if_g.slave));
  measure_ctrl #(.GATE_CYCLES(0),  .MAX_EXPONENT(9)) u_man  (.clk(clk), .rst(rst), .bus(if_m.slave));
  measure_ctrl #(.GATE_CYCLES(0),  .MAX_EXPONENT(1)) u_ovf  (.clk(clk), .rst(rst), .bus(if_o.slave));

  logic [2:0] start_v = 3'b000;
  logic [2:0] stop_v  = 3'b000;
  logic [2:0] busy_v, done_v, en_v, crst_v, ovf_v;
  logic [6:0] rbase_v [3];
  logic [3:0] rexp_v  [3];
  int unsigned cnt [3];
  int done_seen [3];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int id;
    int base;
    int expo;
    int ovf;
  } exp_t;
  exp_t sb_q [$];

  // Decade counter model: base 0..99, exponent counts decades above that.
  function automatic logic [10:0] decade(int unsigned c);
    int unsigned v = c;
    logic [3:0] e = 4'd0;
    while (v >= 100) begin
      v = v / 10;
      e = e + 4'd1;
    end
    return {e, 7'(v)};
  endfunction

  assign if_g.start = start_v[0];
  assign if_m.start = start_v[1];
  assign if_o.start = start_v[2];
  assign if_g.stop  = stop_v[0];
  assign if_m.stop  = stop_v[1];
  assign if_o.stop  = stop_v[2];
  assign {if_g.cnt_exponent, if_g.cnt_base} = decade(cnt[0]);
  assign {if_m.cnt_exponent, if_m.cnt_base} = decade(cnt[1]);
  assign {if_o.cnt_exponent, if_o.cnt_base} = decade(cnt[2]);

  assign busy_v = {if_o.busy, if_m.busy, if_g.busy};
  assign done_v = {if_o.done, if_m.done, if_g.done};
  assign en_v   = {if_o.cnt_en, if_m.cnt_en, if_g.cnt_en};
  assign crst_v = {if_o.cnt_rst, if_m.cnt_rst, if_g.cnt_rst};
  assign ovf_v  = {if_o.overflow, if_m.overflow, if_g.overflow};
  assign rbase_v[0] = if_g.result_base;
  assign rbase_v[1] = if_m.result_base;
  assign rbase_v[2] = if_o.result_base;
  assign rexp_v[0]  = if_g.result_exponent;
  assign rexp_v[1]  = if_m.result_exponent;
  assign rexp_v[2]  = if_o.result_exponent;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (crst_v[i]) cnt[i] <= 0;
      else if (en_v[i]) cnt[i] <= cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, want, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i]) begin
        done_seen[i]++;
        if (sb_q.size() == 0) begin
          check("done_unexpected_inst", i, -1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_inst", i, e.id);
          check("sb_base", int'(rbase_v[i]), e.base);
          check("sb_exp", int'(rexp_v[i]), e.expo);
          check("sb_ovf", int'(ovf_v[i]), e.ovf);
        end
      end
    end
  end

  task automatic push(input int id, input int base, input int expo, input int ovf);
    exp_t e;
    e.id = id; e.base = base; e.expo = expo; e.ovf = ovf;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int id, input int budget);
    int n = 0;
    while (!done_v[id] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", int'(done_v[id]), 1);
  endtask

  initial begin
    int n;
    int seen;
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      done_seen[i] = 0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", int'(busy_v[i]), 0);
      check("rst_cnt_en", int'(en_v[i]), 0);
      check("rst_cnt_rst", int'(crst_v[i]), 0);
      check("rst_done", int'(done_v[i]), 0);
      check("rst_ovf", int'(ovf_v[i]), 0);
      check("rst_base", int'(rbase_v[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Stop edge in IDLE is ignored
    stop_v[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_stop_busy", int'(busy_v[1]), 0);
    stop_v[1] = 1'b0;
    @(negedge clk);

    // Gated measurement: 25 RUN cycles, then LATCH, then DONE
    start_v[0] = 1'b1;
    push(0, 25, 0, 0);
    @(negedge clk);
    check("gate_clear_cnt_rst", int'(crst_v[0]), 1);
    check("gate_clear_cnt_en", int'(en_v[0]), 0);
    check("gate_clear_busy", int'(busy_v[0]), 1);
    start_v[0] = 1'b0;
    @(negedge clk);
    check("gate_run_cnt_rst", int'(crst_v[0]), 0);
    check("gate_run_cnt_en", int'(en_v[0]), 1);
    n = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (en_v[0]) n++;
      else break;
    end
    check("gate_run_len", n, 25);
    check("gate_latch_done", int'(done_v[0]), 0);
    check("gate_latch_busy", int'(busy_v[0]), 1);
    @(negedge clk);
    check("gate_done_pulse", int'(done_v[0]), 1);
    @(negedge clk);
    check("gate_done_width", int'(done_v[0]), 0);
    check("gate_idle_busy", int'(busy_v[0]), 0);
    repeat (3) @(negedge clk);
    check("gate_result_hold", int'(rbase_v[0]), 25);

    // Manual stop on the 10th RUN cycle
    start_v[1] = 1'b1;
    push(1, 10, 0, 0);
    @(negedge clk);
    start_v[1] = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    check("man_run10_en", int'(en_v[1]), 1);
    stop_v[1] = 1'b1;
    wait_done(1, 20);
    stop_v[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("man_done_once", done_seen[1], 1);

    // Simultaneous start and stop edges in RUN act as stop only
    start_v[1] = 1'b1;
    push(1, 5, 0, 0);
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (5) @(negedge clk);
    start_v[1] = 1'b1;
    stop_v[1]  = 1'b1;
    wait_done(1, 20);
    repeat (2) @(negedge clk);
    check("simul_busy_after_done", int'(busy_v[1]), 0);
    repeat (5) @(negedge clk);
    check("simul_no_restart", int'(busy_v[1]), 0);
    start_v[1] = 1'b0;
    stop_v[1]  = 1'b0;
    @(negedge clk);

    // Full scale with MAX_EXPONENT=1
    start_v[2] = 1'b1;
    push(2, 99, 1, 1);
    @(negedge clk);
    start_v[2] = 1'b0;
    wait_done(2, 1200);
    repeat (2) @(negedge clk);
    check("ovf_hold", int'(ovf_v[2]), 1);

    // Reset in the middle of RUN aborts without done
    seen = done_seen[0];
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_pre_en", int'(en_v[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_cnt_en", int'(en_v[0]), 0);
    check("abort_busy", int'(busy_v[0]), 0);
    check("abort_result", int'(rbase_v[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_done", done_seen[0], seen);
    check("abort_idle", int'(busy_v[0]), 0);
    start_v[0] = 1'b1;
    push(0, 25, 0, 0);
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 100);
    @(negedge clk);

    // Start held high across reset release is not an edge
    rst = 1'b1;
    start_v[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("held_start_idle", int'(busy_v[1]), 0);
    start_v[1] = 1'b0;
    @(negedge clk);
    start_v[1] = 1'b1;
    push(1, 3, 0, 0);
    @(negedge clk);
    check("held_new_clear", int'(crst_v[1]), 1);
    start_v[1] = 1'b0;
    repeat (3) @(negedge clk);
    stop_v[1] = 1'b1;
    wait_done(1, 20);
    stop_v[1] = 1'b0;
    repeat (3) @(negedge clk);

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
